// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads words from the instruction ROM,
// buffers {pc, instr} pairs in a small FIFO and handles redirects and fetch faults.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  typedef enum logic [1:0] {S_RUN, S_FULL, S_FAULT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [31:0]   head_data_q, head_data_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_pc_q, fault_pc_d;

  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];

  logic          pc_oob;
  logic          redirect_bad;
  logic          xfer;
  logic          pop;
  logic          do_push;
  logic          do_pop;

  // Request is a pure decode of registered state, so decode-side ready never reaches the ROM.
  assign pc_oob       = (fetch_pc_q >= PC_LIMIT);
  assign imem_req     = !reset && (state_q == S_RUN) && !pc_oob;
  assign imem_addr    = fetch_pc_q;
  assign xfer         = imem_req && imem_ready;
  assign pop          = valid_q && instr_ready;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);

  assign instr_valid  = valid_q;
  assign instr_data   = head_data_q;
  assign instr_pc     = head_pc_q;
  assign fetch_fault  = fault_q;
  assign fault_pc     = fault_pc_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    valid_d     = 1'b0;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;

    if (state_q == S_FAULT) begin
      count_d = '0;
    end else if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (redirect_bad) begin
        state_d    = S_FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end else begin
        state_d    = S_RUN;
        fetch_pc_d = redirect_pc;
      end
    end else if ((state_q == S_RUN) && pc_oob) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      state_d    = S_FAULT;
      fault_d    = 1'b1;
      fault_pc_d = fetch_pc_q;
    end else begin
      do_push = xfer;
      do_pop  = pop;
      if (do_push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      state_d = (count_d == CW'(DEPTH)) ? S_FULL : S_RUN;
    end

    // Head register bypasses the array when the new head is the word arriving this cycle.
    valid_d = (count_d != '0);
    if (valid_d) begin
      if (do_push && (count_q == CW'(do_pop))) begin
        head_data_d = imem_rdata;
        head_pc_d   = fetch_pc_q;
      end else begin
        head_data_d = mem_data_q[rd_ptr_d];
        head_pc_d   = mem_pc_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      fetch_pc_q  <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      head_data_q <= '0;
      head_pc_q   <= '0;
      fault_q     <= 1'b0;
      fault_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      fault_q     <= fault_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
      mem_data_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
